// File: rtl/codec_stream_ctrl.sv
// codec_stream_ctrl
//   Sequences stereo samples between the audio CODEC handshake and the
//   encrypt -> BPSK -> channel -> BPSK -> decrypt pipeline.  Traffic is held
//   off until both RC4 keystream generators are initialised.  Samples are then
//   pulled from the CODEC ADC and issued into the pipeline.  Returning samples
//   are buffered in a small stereo FIFO and drained into the CODEC DAC.  A
//   credit count bounds the number of in-flight samples, and a watchdog
//   recovers credits for samples the pipeline loses.
//
// Handshake semantics (all strobes are single-cycle, no back-pressure):
//   read     : asserted for exactly one cycle; readdata_* are captured in that
//              cycle.  Never asserted on consecutive cycles.
//   tx_valid : one-cycle pulse; tx_* hold the captured pair in that cycle.
//   rx_valid : the pipeline presents rx_* for one cycle; the block always
//              accepts it (the data is dropped if the FIFO is full).
//   write    : asserted for exactly one cycle while writedata_* show the FIFO
//              head; the head is popped at the end of that cycle.
//
// Ports
//   CLOCK_50                     system clock, rising edge
//   resetn                       asynchronous active-low reset
//   init_done_l/_r               RC4 keystream ready, left/right
//   read_ready                   CODEC has an ADC pair
//   readdata_left/_right [23:0]  CODEC ADC data
//   read                         CODEC read strobe
//   tx_left/_right [23:0]        sample into the pipeline
//   tx_valid                     tx_* valid this cycle
//   rx_left/_right [23:0]        sample from the pipeline
//   rx_valid                     rx_* valid this cycle
//   write_ready                  CODEC can accept a DAC pair
//   writedata_left/_right [23:0] FIFO head to the CODEC
//   write                        CODEC write strobe
//   sample_count [15:0]          completed CODEC writes, wraps
//   overflow                     sticky: rx_valid while FIFO full
//   timeout_err                  sticky: watchdog fired
//   fsm_state                    debug view of the sequencer state
module codec_stream_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        init_done_l,
  input  logic        init_done_r,
  input  logic        read_ready,
  input  logic [23:0] readdata_left,
  input  logic [23:0] readdata_right,
  output logic        read,
  output logic [23:0] tx_left,
  output logic [23:0] tx_right,
  output logic        tx_valid,
  input  logic [23:0] rx_left,
  input  logic [23:0] rx_right,
  input  logic        rx_valid,
  input  logic        write_ready,
  output logic [23:0] writedata_left,
  output logic [23:0] writedata_right,
  output logic        write,
  output logic [15:0] sample_count,
  output logic        overflow,
  output logic        timeout_err,
  output logic [0:0]  fsm_state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] WAIT_INIT = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;

  logic [47:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  inflight;
  logic [WDW-1:0] wd_cnt;

  logic        init_ok;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        has_credit;
  logic        inflight_dec;
  logic        wd_clear;
  logic        wd_fire;
  logic [CW:0] occupied;
  logic [47:0] head;

  assign init_ok   = init_done_l && init_done_r;
  assign fifo_full = (fifo_count == CW'(DEPTH));
  // A full FIFO drops the incoming pair even if a pop happens in the same
  // cycle; credits make this a fault condition only.
  assign push      = rx_valid && !fifo_full;
  // write is only raised with a non-empty FIFO and only pops remove entries,
  // so the FIFO is still non-empty in the write cycle.
  assign pop       = write;

  // Buffered plus in-flight samples must stay below DEPTH for a new read.
  assign occupied   = {1'b0, fifo_count} + {1'b0, inflight};
  assign has_credit = (occupied < (CW + 1)'(DEPTH));

  assign inflight_dec = rx_valid && (inflight != '0);
  assign wd_clear     = rx_valid || (inflight == '0);
  assign wd_fire      = !wd_clear && (wd_cnt == WDW'(TIMEOUT - 1));

  // Empty FIFO presents zero rather than stale storage.
  assign head            = mem[rd_ptr];
  assign writedata_left  = (fifo_count != '0) ? head[47:24] : 24'd0;
  assign writedata_right = (fifo_count != '0) ? head[23:0]  : 24'd0;

  // Sequencer: only gates new reads; draining continues in both states.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      fsm_state <= WAIT_INIT;
    end else begin
      case (fsm_state)
        WAIT_INIT: if (init_ok)  fsm_state <= RUN;
        RUN:       if (!init_ok) fsm_state <= WAIT_INIT;
        default:   fsm_state <= WAIT_INIT;
      endcase
    end
  end

  // ADC side: read strobe, capture, pipeline issue.  Blocking on tx_valid
  // keeps the credit check honest because inflight counts the sample only
  // after its tx_valid cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      read     <= 1'b0;
      tx_valid <= 1'b0;
      tx_left  <= 24'd0;
      tx_right <= 24'd0;
    end else begin
      read     <= (fsm_state == RUN) && read_ready && has_credit && !read && !tx_valid;
      tx_valid <= read;
      if (read) begin
        tx_left  <= readdata_left;
        tx_right <= readdata_right;
      end
    end
  end

  // In-flight credit count and watchdog.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      inflight    <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wd_fire) begin
        inflight    <= '0;
        timeout_err <= 1'b1;
      end else begin
        case ({tx_valid, inflight_dec})
          2'b10:   if (inflight != CW'(DEPTH)) inflight <= inflight + 1'b1;
          2'b01:   inflight <= inflight - 1'b1;
          default: inflight <= inflight;
        endcase
      end
      if (wd_clear || wd_fire) wd_cnt <= '0;
      else                     wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Return FIFO storage; contents are qualified by fifo_count so it needs no
  // reset.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {rx_left, rx_right};
  end

  // Return FIFO control, DAC write strobe, counters and overflow flag.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      write        <= 1'b0;
      sample_count <= 16'd0;
      overflow     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      write <= (fifo_count != '0) && write_ready && !write;
      if (pop) sample_count <= sample_count + 16'd1;
      if (rx_valid && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_codec_stream_ctrl.sv
// Self-checking bench for codec_stream_ctrl: init gating table, loopback,
// credit back-pressure, simultaneous push/pop, watchdog, overflow and
// asynchronous reset.
module tb_codec_stream_ctrl;

  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 1024;
  localparam int LOOP_DLY = 5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic        init_done_l, init_done_r, read_ready, rx_valid, write_ready;
  logic [23:0] readdata_left, readdata_right, rx_left, rx_right;
  logic        read, tx_valid, write, overflow, timeout_err;
  logic [23:0] tx_left, tx_right, writedata_left, writedata_right;
  logic [15:0] sample_count;
  logic [0:0]  fsm_state;

  always #5 clk = ~clk;

  codec_stream_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50(clk), .resetn(resetn),
    .init_done_l(init_done_l), .init_done_r(init_done_r),
    .read_ready(read_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .read(read), .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
    .write_ready(write_ready),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .write(write), .sample_count(sample_count),
    .overflow(overflow), .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          due;
  } pipe_t;

  pipe_t       pipe_q[$];
  logic [47:0] tx_exp_q[$];
  logic [47:0] wr_exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt, wr_cnt, tx_cnt, rd_limit;
  int first_wr_cyc, first_tx_cyc, last_rd_cyc;
  bit loop_en, rand_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: strobe with no expected entry (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    resetn         = 1'b0;
    init_done_l    = 1'b0;
    init_done_r    = 1'b0;
    read_ready     = 1'b0;
    write_ready    = 1'b0;
    rx_valid       = 1'b0;
    rx_left        = 24'd0;
    rx_right       = 24'd0;
    readdata_left  = 24'd0;
    readdata_right = 24'd0;
    loop_en        = 1'b0;
    rand_data      = 1'b0;
    pipe_q.delete();
    tx_exp_q.delete();
    wr_exp_q.delete();
    rd_cnt       = 0;
    wr_cnt       = 0;
    tx_cnt       = 0;
    rd_limit     = 1000;
    first_wr_cyc = -1;
    first_tx_cyc = -1;
    last_rd_cyc  = -1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // One clock: observe outputs 1 time unit after the edge, score them, then
  // drive the inputs for the next edge (ADC data, pipeline model returns).
  task automatic step();
    logic [47:0] e;
    pipe_t       p;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_valid) begin
      tx_cnt++;
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
      if (tx_exp_q.size() == 0) unexpected("tx_valid");
      else begin
        e = tx_exp_q.pop_front();
        check("tx_data", {tx_left, tx_right}, e);
        if (loop_en) begin
          p.l = e[47:24];
          p.r = e[23:0];
          p.due = cyc + LOOP_DLY;
          pipe_q.push_back(p);
        end
      end
    end
    if (write) begin
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (wr_exp_q.size() == 0) unexpected("write");
      else begin
        e = wr_exp_q.pop_front();
        check("writedata", {writedata_left, writedata_right}, e);
      end
    end
    if (read) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      tx_exp_q.push_back({readdata_left, readdata_right});
      if (rd_cnt >= rd_limit) read_ready = 1'b0;
    end else if (rand_data) begin
      readdata_left  = 24'($urandom);
      readdata_right = 24'($urandom);
    end
    rx_valid = 1'b0;
    if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      p = pipe_q.pop_front();
      rx_valid = 1'b1;
      rx_left  = p.l;
      rx_right = p.r;
      wr_exp_q.push_back({p.l, p.r});
    end
  endtask

  // Present one pair on the return port for the next edge.
  task automatic inject(input logic [23:0] l, input logic [23:0] r, input bit expect_kept);
    rx_valid = 1'b1;
    rx_left  = l;
    rx_right = r;
    if (expect_kept) wr_exp_q.push_back({l, r});
  endtask

  // ---------------- init gating vector table ----------------
  typedef struct {
    logic il;
    logic ir;
    logic rdy;
    int   exp_first_read;  // step index of first read, 0 = none in 6 steps
  } init_vec_t;

  init_vec_t tbl[6];

  // ---------------- test sequence ----------------
  initial begin
    int first;
    int te_cyc;
    int n;

    tbl[0] = '{il: 1'b0, ir: 1'b0, rdy: 1'b1, exp_first_read: 0};
    tbl[1] = '{il: 1'b1, ir: 1'b0, rdy: 1'b1, exp_first_read: 0};
    tbl[2] = '{il: 1'b0, ir: 1'b1, rdy: 1'b1, exp_first_read: 0};
    tbl[3] = '{il: 1'b1, ir: 1'b1, rdy: 1'b0, exp_first_read: 0};
    tbl[4] = '{il: 1'b1, ir: 1'b1, rdy: 1'b1, exp_first_read: 2};
    tbl[5] = '{il: 1'b0, ir: 0,    rdy: 1'b0, exp_first_read: 0};

    // Reset values
    do_reset();
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx", {tx_left, tx_right}, 0);
    check("rst_writedata", {writedata_left, writedata_right}, 0);
    check("rst_sample_count", sample_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_state", fsm_state, 0);

    // Init gating table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      init_done_l = tbl[i].il;
      init_done_r = tbl[i].ir;
      read_ready  = tbl[i].rdy;
      first = 0;
      for (int s = 1; s <= 6; s++) begin
        step();
        if (read && first == 0) first = s;
      end
      check("init_tbl_first_read", first, tbl[i].exp_first_read);
    end

    // Init gating, long hold with one side ready
    do_reset();
    init_done_l    = 1'b1;
    read_ready     = 1'b1;
    readdata_left  = 24'h123456;
    readdata_right = 24'hABCDEF;
    repeat (50) step();
    check("gate_no_reads", rd_cnt, 0);
    init_done_r = 1'b1;
    rd_limit    = 1;
    step();
    check("gate_read_p1", read, 0);
    step();
    check("gate_read_p2", read, 1);
    step();
    check("gate_tx_valid", tx_valid, 1);
    check("gate_tx_left", tx_left, 24'h123456);
    check("gate_tx_right", tx_right, 24'hABCDEF);
    step();
    check("gate_tx_pulse", tx_valid, 0);

    // Loopback of 10 samples
    do_reset();
    init_done_l = 1'b1;
    init_done_r = 1'b1;
    write_ready = 1'b1;
    rand_data   = 1'b1;
    loop_en     = 1'b1;
    rd_limit    = 10;
    read_ready  = 1'b1;
    n = 0;
    while (wr_cnt < 10 && n < 300) begin
      step();
      n++;
    end
    repeat (5) step();
    check("loop_reads", rd_cnt, 10);
    check("loop_writes", wr_cnt, 10);
    check("loop_sample_count", sample_count, 10);
    check("loop_tx_q_empty", tx_exp_q.size(), 0);
    check("loop_wr_q_empty", wr_exp_q.size(), 0);

    // Credit back-pressure
    do_reset();
    init_done_l = 1'b1;
    init_done_r = 1'b1;
    rand_data   = 1'b1;
    loop_en     = 1'b1;
    read_ready  = 1'b1;
    repeat (80) step();
    check("credit_reads", rd_cnt, DEPTH);
    check("credit_no_write", wr_cnt, 0);
    write_ready = 1'b1;
    n = 0;
    while (rd_cnt == DEPTH && n < 20) begin
      step();
      n++;
    end
    check("credit_resume", rd_cnt, DEPTH + 1);
    check("credit_after_pop", (first_wr_cyc >= 0 && last_rd_cyc > first_wr_cyc), 1);
    read_ready = 1'b0;
    repeat (60) step();
    check("credit_all_written", wr_cnt, rd_cnt);
    check("credit_wr_q_empty", wr_exp_q.size(), 0);

    // Simultaneous push and pop
    do_reset();
    inject(24'h000A01, 24'h000A02, 1);
    step();
    inject(24'h000B01, 24'h000B02, 1);
    step();
    write_ready = 1'b1;
    step();
    check("pp_write_a", write, 1);
    inject(24'h000C01, 24'h000C02, 1);
    step();
    check("pp_head_b", {writedata_left, writedata_right}, {24'h000B01, 24'h000B02});
    repeat (8) step();
    check("pp_writes", wr_cnt, 3);
    check("pp_wr_q_empty", wr_exp_q.size(), 0);
    check("pp_sample_count", sample_count, 3);

    // Overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      inject(24'($urandom), 24'($urandom), 1);
      step();
    end
    check("ovf_clear_before", overflow, 0);
    inject(24'hDEAD00, 24'hBEEF00, 0);
    step();
    step();
    check("ovf_set", overflow, 1);
    write_ready = 1'b1;
    repeat (20) step();
    check("ovf_writes", wr_cnt, DEPTH);
    check("ovf_wr_q_empty", wr_exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);

    // Watchdog: credits exhausted by lost samples, recovered by the timeout
    do_reset();
    init_done_l = 1'b1;
    init_done_r = 1'b1;
    write_ready = 1'b1;
    rand_data   = 1'b1;
    rd_limit    = DEPTH;
    read_ready  = 1'b1;
    te_cyc = -1;
    n = 0;
    while (te_cyc < 0 && n < TIMEOUT + 100) begin
      step();
      n++;
      if (timeout_err) te_cyc = cyc;
    end
    check("wd_fired", timeout_err, 1);
    check("wd_fire_cycle", te_cyc, first_tx_cyc + 1 + TIMEOUT);
    check("wd_reads_before", rd_cnt, DEPTH);
    rd_limit   = DEPTH + 1;
    read_ready = 1'b1;
    step();
    check("wd_read_resumes", read, 1);
    repeat (3) step();
    check("wd_tx_q_empty", tx_exp_q.size(), 0);

    // Asynchronous reset mid-stream
    do_reset();
    init_done_l = 1'b1;
    init_done_r = 1'b1;
    write_ready = 1'b1;
    rand_data   = 1'b1;
    loop_en     = 1'b1;
    read_ready  = 1'b1;
    repeat (25) step();
    check("mid_active", (sample_count != 0), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_read", read, 0);
    check("arst_write", write, 0);
    check("arst_tx_valid", tx_valid, 0);
    check("arst_tx", {tx_left, tx_right}, 0);
    check("arst_writedata", {writedata_left, writedata_right}, 0);
    check("arst_sample_count", sample_count, 0);
    check("arst_state", fsm_state, 0);
    do_reset();
    repeat (3) step();
    check("arst_no_writes", wr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
